// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream bundle for cla_pipe_adder: valid/ready in, valid/ready out.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH split into STAGES segments,
// registered carry between segments, global stall on output backpressure.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  bus
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned NGRP = SEG / BLOCK;

  typedef struct packed {
    logic           cout;
    logic [SEG-1:0] s;
  } seg_res_t;

  // Each bit carry inside a group is formed directly from the group carry-in;
  // only group-to-group carries ripple.
  function automatic seg_res_t cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                       input logic ci);
    seg_res_t     r;
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           cg;
    logic           pp;
    logic           term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      cg = c[grp*BLOCK];
      for (int unsigned j = 1; j <= BLOCK; j++) begin
        term = 1'b0;
        pp   = 1'b1;
        for (int unsigned i = j; i > 0; i--) begin
          term = term | (g[grp*BLOCK+i-1] & pp);
          pp   = pp & p[grp*BLOCK+i-1];
        end
        c[grp*BLOCK+j] = term | (pp & cg);
      end
    end
    r.s    = p ^ c[SEG-1:0];
    r.cout = c[SEG];
    return r;
  endfunction

  logic en;

  assign en           = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO     = k * SEG;
    localparam int unsigned REM_IN = WIDTH - LO;

    logic              v_s;
    logic              c_s;
    logic [REM_IN-1:0] a_s;
    logic [REM_IN-1:0] b_s;
    logic [LO+SEG-1:0] sum_d;
    seg_res_t          res;

    logic              v_q;
    logic              c_q;
    logic [LO+SEG-1:0] sum_q;

    if (k == 0) begin : g_in
      assign v_s   = bus.in_valid;
      assign a_s   = bus.a;
      assign b_s   = bus.sub ? ~bus.b : bus.b;
      assign c_s   = bus.cin ^ bus.sub;
      assign sum_d = res.s;
    end else begin : g_chain
      assign v_s   = g_stg[k-1].v_q;
      assign a_s   = g_stg[k-1].g_skew.a_q;
      assign b_s   = g_stg[k-1].g_skew.b_q;
      assign c_s   = g_stg[k-1].c_q;
      assign sum_d = {res.s, g_stg[k-1].sum_q};
    end

    always_comb begin
      res = cla_seg(a_s[SEG-1:0], b_s[SEG-1:0], c_s);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_s;
        c_q   <= res.cout;
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM_IN-SEG-1:0] a_q;
      logic [REM_IN-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_s[REM_IN-1:SEG];
          b_q <= b_s[REM_IN-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;

      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      assign ovf_d  = res.cout ^ (res.s[SEG-1] ^ a_s[SEG-1] ^ b_s[SEG-1]);
      assign zero_d = ~|sum_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign bus.out_valid = v_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = c_q;
      assign bus.ovf       = ovf_q;
      assign bus.zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors, streaming with stall,
// mid-stream reset, and random streams over several parameter sets.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nrun = 0;
  int   nfail = 0;
  int   ndone = 0;
  bit   go = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] sum; logic cout; logic ovf; logic zero; } res_t;
  typedef struct { res_t r; int cyc; bit chk; } sb_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic cin; logic sub;
                   logic [31:0] s; logic c; logic v; logic z; } vec_t;

  // Reference: exact integer arithmetic in 128 bits, range-checked for overflow.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input int w);
    logic [127:0]        ua, ub, u;
    logic signed [127:0] sa, sb, t, lim, ci;
    logic [63:0]         mask;
    res_t                r;
    mask = (64'd1 << w) - 64'd1;
    ua = {64'd0, a};
    ub = {64'd0, b};
    ci = $signed({127'd0, cin});
    sa = ua;
    sb = ub;
    if (a[w-1]) sa = sa - (128'sd1 <<< w);
    if (b[w-1]) sb = sb - (128'sd1 <<< w);
    if (sub) begin
      u = ua - ub - {127'd0, cin};
      t = sa - sb - ci;
      r.cout = (ua >= ub + {127'd0, cin});
    end else begin
      u = ua + ub + {127'd0, cin};
      t = sa + sb + ci;
      r.cout = u[w];
    end
    r.sum  = u[63:0] & mask;
    lim    = 128'sd1 <<< (w - 1);
    r.ovf  = (t >= lim) || (t < -lim);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic sub, input logic [31:0] s, input logic c,
                                 input logic v, input logic z);
    vec_t x;
    x.a = a; x.b = b; x.cin = cin; x.sub = sub; x.s = s; x.c = c; x.v = v; x.z = z;
    return x;
  endfunction

  function automatic res_t v2r(input vec_t x);
    res_t r;
    r.sum = {32'd0, x.s}; r.cout = x.c; r.ovf = x.v; r.zero = x.z;
    return r;
  endfunction

  function automatic sb_t mksb(input res_t r, input bit chk);
    sb_t s;
    s.r = r; s.cyc = cyc; s.chk = chk;
    return s;
  endfunction

  task automatic chk_res(input string name, input logic [63:0] gs, input logic gc,
                         input logic gv, input logic gz, input res_t e);
    nrun++;
    if (gs !== e.sum || gc !== e.cout || gv !== e.ovf || gz !== e.zero) begin
      nfail++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
               name, gs, gc, gv, gz, e.sum, e.cout, e.ovf, e.zero);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    nrun++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- main DUT: WIDTH=32, STAGES=2, BLOCK=4 ----------------
  cla_pipe_adder_if #(.WIDTH(32)) mif ();

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  sb_t         mq[$];
  logic        stall_prev = 1'b0;
  logic [31:0] snap_s;
  logic        snap_c, snap_v, snap_z;

  always @(negedge clk) begin
    sb_t  e;
    res_t hold;
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        hold.sum = {32'd0, snap_s}; hold.cout = snap_c; hold.ovf = snap_v; hold.zero = snap_z;
        chk_res("stall_hold", {32'd0, mif.sum}, mif.cout, mif.ovf, mif.zero, hold);
        chk_int("stall_valid", int'(mif.out_valid), 1);
      end
      if (mif.out_valid && !mif.out_ready)
        chk_int("stall_in_ready", int'(mif.in_ready), 0);
      if (mif.out_valid && mif.out_ready) begin
        if (mq.size() == 0) begin
          nrun++;
          nfail++;
          $display("FAIL spurious_out: got out_valid=1 sum=%h, expected no pending beat", mif.sum);
        end else begin
          e = mq.pop_front();
          chk_res("result", {32'd0, mif.sum}, mif.cout, mif.ovf, mif.zero, e.r);
          if (e.chk) chk_int("latency", cyc - e.cyc, 2);
        end
      end
      stall_prev <= mif.out_valid && !mif.out_ready;
      snap_s <= mif.sum;
      snap_c <= mif.cout;
      snap_v <= mif.ovf;
      snap_z <= mif.zero;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input res_t e, input bit chk);
    bit fired = 1'b0;
    mif.a = a; mif.b = b; mif.cin = cin; mif.sub = sub; mif.in_valid = 1'b1;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      if (mif.in_ready) begin
        mq.push_back(mksb(e, chk));
        fired = 1'b1;
      end
      @(posedge clk); #1;
    end
    mif.in_valid = 1'b0;
    chk_int("send_accepted", int'(fired), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 0) break;
      @(posedge clk); #1;
    end
    chk_int("drain", mq.size(), 0);
  endtask

  task automatic stream(input int n, input int stall_at);
    int          sent = 0;
    int          guard = 0;
    logic [31:0] ra, rb;
    logic        rc, rs;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    mif.in_valid = 1'b1;
    while (sent < n && guard < n + 50) begin
      mif.a = ra; mif.b = rb; mif.cin = rc; mif.sub = rs;
      mif.out_ready = !(guard >= stall_at && guard < stall_at + 3);
      @(negedge clk);
      if (mif.in_ready) begin
        mq.push_back(mksb(model({32'd0, ra}, {32'd0, rb}, rc, rs, 32), 1'b0));
        sent++;
        ra = $urandom; rb = $urandom;
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      guard++;
    end
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b1;
    chk_int("stream_sent", sent, n);
  endtask

  // ---------------- parameter sweep DUTs ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W = (gi == 2) ? 64 : (gi == 3) ? 16 : 32;
    localparam int S = (gi == 0) ? 1 : (gi == 3) ? 2 : 4;
    localparam int B = (gi == 2) ? 8 : (gi == 3) ? 2 : 4;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    cla_pipe_adder_if #(.WIDTH(W)) sif ();

    cla_pipe_adder #(.WIDTH(W), .STAGES(S), .BLOCK(B)) dut_sw (
      .clk (clk),
      .rst (rst),
      .bus (sif)
    );

    sb_t q[$];

    always @(negedge clk) begin
      sb_t e;
      if (!rst && sif.out_valid && sif.out_ready) begin
        if (q.size() == 0) begin
          nrun++;
          nfail++;
          $display("FAIL sweep_spurious W=%0d S=%0d: got out_valid=1, expected no pending beat", W, S);
        end else begin
          e = q.pop_front();
          chk_res($sformatf("sweep_result_W%0d_S%0d_B%0d", W, S, B), 64'(sif.sum),
                  sif.cout, sif.ovf, sif.zero, e.r);
          if (e.chk) chk_int($sformatf("sweep_latency_W%0d_S%0d", W, S), cyc - e.cyc, S);
        end
      end
    end

    initial begin : sw_run
      logic [63:0] ra, rb;
      logic        rc, rs;
      sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      sif.a = '0; sif.b = '0; sif.cin = 1'b0; sif.sub = 1'b0;
      wait (go);
      @(posedge clk); #1;
      for (int ph = 0; ph < 2; ph++) begin
        for (int i = 0; i < 100; i++) begin
          ra = {$urandom, $urandom} & MASK;
          rb = {$urandom, $urandom} & MASK;
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          sif.a = ra[W-1:0]; sif.b = rb[W-1:0]; sif.cin = rc; sif.sub = rs;
          sif.in_valid  = (ph == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          sif.out_ready = (ph == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (sif.in_valid && sif.in_ready)
            q.push_back(mksb(model(ra, rb, rc, rs, W), ph == 0));
          @(posedge clk); #1;
        end
        sif.in_valid = 1'b0; sif.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
          if (q.size() == 0) break;
          @(posedge clk); #1;
        end
        chk_int($sformatf("sweep_drain_W%0d_S%0d", W, S), q.size(), 0);
      end
      ndone++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[12];
    res_t zr;
    tbl[0]  = mkvec(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    tbl[1]  = mkvec(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mkvec(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mkvec(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mkvec(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mkvec(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mkvec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mkvec(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mkvec(32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mkvec(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    tbl[10] = mkvec(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    tbl[11] = mkvec(32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    zr.sum = 64'd0; zr.cout = 1'b0; zr.ovf = 1'b0; zr.zero = 1'b0;

    mif.in_valid = 1'b1; mif.out_ready = 1'b1;
    mif.a = $urandom; mif.b = $urandom; mif.cin = 1'b1; mif.sub = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_res("reset_state", {32'd0, mif.sum}, mif.cout, mif.ovf, mif.zero, zr);
      chk_int("reset_valid", int'(mif.out_valid), 0);
    end
    rst = 1'b0;
    mif.in_valid = 1'b0;
    @(negedge clk);
    chk_int("ready_after_reset", int'(mif.in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, v2r(tbl[i]), 1'b1);
      drain();
    end

    stream(100, 40);
    drain();

    // Two beats in flight, then reset: neither may ever emerge.
    mif.a = 32'h11; mif.b = 32'h22; mif.cin = 1'b0; mif.sub = 1'b0; mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.a = 32'h33;
    @(posedge clk); #1;
    rst = 1'b1;
    mif.in_valid = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    chk_int("reset_flush_valid", int'(mif.out_valid), 0);
    chk_res("reset_flush_state", {32'd0, mif.sum}, mif.cout, mif.ovf, mif.zero, zr);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_int("no_stale_1", int'(mif.out_valid), 0);
    @(posedge clk); #1;
    chk_int("no_stale_2", int'(mif.out_valid), 0);
    send(32'h1, 32'h2, 1'b0, 1'b0,
         v2r(mkvec(32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0)), 1'b1);
    drain();

    go = 1'b1;
    for (int i = 0; i < 3000 && ndone < 4; i++) @(posedge clk);
    chk_int("sweep_complete", ndone, 4);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor and the successor of the fixed 32-bit registered CLA. WIDTH is split into STAGES equal segments. Each segment is a BLOCK-grouped CLA, and the carry is registered between segments. A valid/ready handshake with backpressure lets the block sit in streaming datapaths and sustain one operation per cycle. It also produces signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits
STAGES, 2, pipeline depth = number of carry segments; WIDTH % (STAGES*BLOCK) must be 0
BLOCK, 4, CLA group size (bits per generate/propagate group)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset state: out_valid=0, sum=0, cout=0, ovf=0, zero=0. All internal stage valids and skew registers are cleared. in_ready=1 in the cycle after reset.
- Handshake: a beat transfers in when in_valid&&in_ready, and out when out_valid&&out_ready.
- Global advance: en = out_ready || !out_valid, and in_ready = en (combinational).
  - When en=0, every pipeline register, including output regs, holds.
  - Bubbles are not collapsed.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - add: result = a + b + cin.
  - sub: result = a - b - cin.
- Segment k (0..STAGES-1) covers bits [k*SEG +: SEG], with SEG = WIDTH/STAGES.
  - Stage k computes segment k from the registered carry of stage k-1 (stage 0 uses c0).
  - Upper-segment operands are delayed through skew regs; completed lower sum bits travel through deskew regs.
  - Within a segment, group G/P use BLOCK-bit lookahead and ripple across groups only.
- Latency: exactly STAGES accepted-advance cycles. With out_ready held 1, a beat accepted at edge t shows out_valid=1 with its result after edge t+STAGES-1.
  - STAGES=1 gives a single registered stage.
- Throughput: 1 beat/cycle while out_ready=1. Result order equals input order.
- Flags are computed from the final segment and registered with sum:
  - cout = carry out of MSB.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- Stall: while out_valid&&!out_ready, sum/cout/ovf/zero/out_valid are stable and in_ready=0.
- Simultaneous accept-in and accept-out in one cycle is legal and loses nothing.
- in_valid=0 while en=1 inserts a bubble: the valid bit propagates 0, and data regs may update (don't-care).
- Reset mid-operation: every in-flight beat is discarded. out_valid=0 after the reset edge, and no stale result ever appears.
- Wrap-around: sum is modulo 2^WIDTH. The carry beyond the MSB appears only on cout.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0 and sum/cout/ovf/zero=0 throughout; in_ready=1 one cycle after rst falls.
- Carry ripple across all segments (WIDTH=32, STAGES=2): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> out_valid exactly 2 cycles after accept, with sum=0x00000000, cout=1, zero=1, ovf=0.
- Signed overflow, add and sub:
  - 0x7FFFFFFF+0x1 -> sum=0x80000000, ovf=1, cout=0.
  - sub: 0x80000000-0x1 (cin=0) -> sum=0x7FFFFFFF, ovf=1, cout=1.
  - sub: 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - sub: 10-3 with cin=1 -> sum=0x6, cout=1.
- Streaming with backpressure: 100 random beats (random sub/cin) in_valid every cycle, out_ready=1.
  - Expect one result per cycle matching a±b±cin in order.
  - Drop out_ready for 3 cycles mid-stream -> outputs held stable, in_ready=0, no loss or duplication, compared against a FIFO scoreboard.
- Reset mid-stream: rst asserted with 2 beats in flight -> out_valid=0 the next cycle. The first post-reset beat 0x1+0x2 returns sum=0x3 after 2 cycles.
- Parameter sweep: repeat the random scoreboard test for (WIDTH,STAGES,BLOCK) = (32,1,4), (32,4,4), (64,4,8), (16,2,2) -> zero mismatches; latency equals STAGES in each.
